// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field-level requests into 32-bit words and writes them to IMEM.
// Optional immediate range checking is enabled by defining ENCODER_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | ready for a request; legal requests are encoded and latched
// WRITE | imem_we asserted for the latched word; pointer and count advance
// FULL  | every IMEM word written; only clear or reset leaves this state
module instr_encoder #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [6:0]        op,
   input  logic [2:0]        funct3,
   input  logic              funct7b5,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [31:0]       imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   cnt;
   logic [ADDR_W:0]   cnt_inc;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       word_q;
   logic              err_q;

   logic [31:0]       enc_word;
   logic              fmt_ok;
   logic              range_ok;
   logic              is_shift;
   logic              legal;

   assign is_shift = (op == 7'b0010011) && ((funct3 == 3'b001) || (funct3 == 3'b101));

   always_comb begin
      enc_word = 32'h0;
      fmt_ok   = 1'b1;
      case (fmt)
         3'd0: enc_word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, op};
         3'd1: begin
            if (is_shift)
               enc_word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, op};
            else
               enc_word = {imm[11:0], rs1, funct3, rd, op};
         end
         3'd2: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
         3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
         3'd4: enc_word = {imm[31:12], rd, op};
         3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default: fmt_ok = 1'b0;
      endcase
   end

`ifdef ENCODER_RANGE_CHECK_EN
   // A value fits in an N-bit signed field when bits [31:N-1] are all equal.
   always_comb begin
      range_ok = 1'b1;
      case (fmt)
         3'd1, 3'd2: range_ok = (&imm[31:11]) || !(|imm[31:11]);
         3'd3:       range_ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
         3'd4:       range_ok = (imm[11:0] == 12'h000);
         3'd5:       range_ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
         default:    range_ok = 1'b1;
      endcase
   end
`else
   assign range_ok = 1'b1;
`endif

   assign legal   = fmt_ok && range_ok;
   assign cnt_inc = cnt + CNT_ONE;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (in_valid && legal)
               state_nx = WRITE;
         end
         WRITE: begin
            if (clear)
               state_nx = IDLE;
            else if (cnt_inc == CAPACITY)
               state_nx = FULL;
            else
               state_nx = IDLE;
         end
         FULL: begin
            if (clear)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= '0;
         cnt    <= '0;
         addr_q <= '0;
         word_q <= 32'h0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (clear) begin
                  ptr   <= '0;
                  cnt   <= '0;
                  err_q <= 1'b0;
               end
               // A request arriving together with clear lands at address 0.
               if (in_valid) begin
                  if (legal) begin
                     word_q <= enc_word;
                     addr_q <= clear ? '0 : ptr;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (clear) begin
                  ptr   <= '0;
                  cnt   <= '0;
                  err_q <= 1'b0;
               end else begin
                  ptr <= ptr + PTR_ONE;
                  cnt <= cnt_inc;
               end
            end
            FULL: begin
               if (clear) begin
                  ptr   <= '0;
                  cnt   <= '0;
                  err_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Reset is sampled at the edge, so gate the strobe to kill a write in the reset cycle.
   assign imem_we    = (state == WRITE) && !reset;
   assign in_ready   = (state == IDLE);
   assign full       = (state == FULL);
   assign imem_addr  = addr_q;
   assign imem_wdata = word_q;
   assign count      = cnt;
   assign err        = err_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder that packs field-level requests into 32-bit instruction words and writes them, one per request, into instruction memory through a single write port. It performs the inverse of the datapath controller's decode: format select, opcode, funct3, funct7b5, register indices and immediate go in, and the canonical encoded word comes out. It is used by the boot/self-test path to build programs in IMEM before the core is released from reset.

## Interface
Parameters:
- ADDR_W, 8, width of IMEM word address and write pointer; capacity 2^ADDR_W words.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous; resets pointer, full, err; ignored while reset is high.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- fmt  in  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6 and 7 are illegal.
- op  in  7  opcode, placed in bits [6:0] unchanged.
- funct3  in  3  placed in [14:12] for R/I/S/B.
- funct7b5  in  1  R: bit 30; I shift (op 0010011, funct3 001/101): bit 30.
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  signed immediate (byte offset for B/J; full value for U).
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since reset/clear.
- full  out  1  all 2^ADDR_W words written.
- err  out  1  sticky; a request was dropped.

## Operation
- FSM states: IDLE, WRITE, FULL.
- IDLE: in_ready=1. On in_valid, latch the encoded word and the pointer. A legal request goes to WRITE; an illegal request stays in IDLE, sets err, and is dropped with no write.
- WRITE: imem_we=1, imem_addr=ptr, imem_wdata=latched word, in_ready=0. Next cycle: ptr+1, count+1. If count reaches 2^ADDR_W, go to FULL; otherwise go to IDLE.
- FULL: in_ready=0, full=1. Requests are not accepted. Only clear or reset leaves FULL, returning to IDLE.
- Encodings:
  - R: {0,funct7b5,00000, rs2, rs1, f3, rd, op}
  - I: {imm[11:0], rs1, f3, rd, op}; I shift replaces imm[11:5] with {0,funct7b5,00000}.
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Illegal requests: fmt 6 or 7 always. Range violations per Configuration.
- clear in WRITE: the write in progress completes, then ptr, count, full and err return to 0 and the FSM goes to IDLE.

## Timing
- Reset values: state IDLE, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, err=0. A reset asserted during WRITE suppresses that cycle's imem_we.
- Accept in cycle N gives imem_we in cycle N+1. The next accept is possible in cycle N+2, so peak throughput is 1 word per 2 cycles.
- in_ready is a function of state only; it has no combinational path from in_valid.
- imem_addr and imem_wdata hold their values outside WRITE. imem_we=0 in all states except WRITE.
- err sets in the cycle after the illegal accept.

## Configuration
- ENCODER_RANGE_CHECK_EN defined: immediates are range-checked, and an out-of-range request is illegal (dropped, err set).
  - I/S: signed 12-bit range.
  - B: signed 13-bit range, imm[0]=0.
  - J: signed 21-bit range, imm[0]=0.
  - U: imm[11:0]=0.
- ENCODER_RANGE_CHECK_EN undefined: no range check. Immediate bits are silently truncated per the encoding, and err is set only for fmt 6/7.

## Test plan
- fmt=1 op=0010011 f3=000 rd=1 rs1=0 imm=5 (addi x1,x0,5) -> imem_we one cycle later, addr 0, wdata 0x00500093, count=1.
- Back-to-back requests, in_valid held high: add x3,x1,x2 (fmt0, op 0110011) -> 0x002081B3 at addr 0; sw x2,8(x1) (fmt2, f3=010) -> 0x0020A423 at addr 1. Verify in_ready=0 during each WRITE cycle.
- beq x0,x0,-4 -> 0xFE000EE3. jal x1,8 -> 0x008000EF. lui x5 with imm=0x12345000 -> 0x123452B7.
- With ENCODER_RANGE_CHECK_EN, addi with imm=2048 -> no imem_we, err=1, count unchanged. Same stimulus without the macro -> wdata 0x80000093, err=0. fmt=7 -> err=1 in both builds.
- ADDR_W=2, four legal writes -> full=1, in_ready=0, a fifth request is ignored. Then pulse clear -> count=0, full=0, and the next write goes to addr 0.
- Assert reset in the WRITE cycle -> imem_we=0 that cycle, all outputs take their reset values.
